// File: rtl/host_line_shim.sv
// host_line_shim: bridges the proc 512b line port to a 64b host bus.
// Optional watchdog enabled by defining HOST_SHIM_TIMEOUT_EN.
module host_line_shim #(
  parameter int HOST_W      = 64,
  parameter int LINE_W      = 512,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [LINE_W-1:0] line_wr_data,
  input  logic [63:0]       cv_value,
  output logic [LINE_W-1:0] line_rd_data,
  output logic              tx_done,
  output logic              rd_valid,
  output logic              host_req_valid,
  input  logic              host_req_ready,
  output logic              host_req_wr,
  output logic [ADDR_W-1:0] host_req_addr,
  output logic [3:0]        host_req_beats,
  output logic              host_wr_valid,
  input  logic              host_wr_ready,
  output logic [HOST_W-1:0] host_wr_data,
  input  logic              host_rd_valid,
  input  logic [HOST_W-1:0] host_rd_data,
  output logic              shim_err
);
  localparam int NB = LINE_W / HOST_W;
  localparam logic [2:0] LAST = 3'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, RD_BEAT, RD_DONE,
    RD_VLD, WR_BEAT, WR_DONE, DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [63:0]       cv_q, cv_d;
  logic [2:0]        beat_q, beat_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic              to_hit;
  logic              is_cv, is_rd;

  assign is_cv = op_q == 2'b10;
  assign is_rd = op_q == 2'b01;
  assign line_rd_data = rd_line_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    cv_d      = cv_q;
    beat_d    = beat_q;
    rd_line_d = rd_line_q;
    tx_done        = 1'b0;
    rd_valid       = 1'b0;
    host_req_valid = 1'b0;
    host_req_wr    = 1'b0;
    host_req_addr  = '0;
    host_req_beats = '0;
    host_wr_valid  = 1'b0;
    host_wr_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (op != 2'b00) begin
          op_d      = op;
          addr_d    = io_addr;
          wr_line_d = line_wr_data;
          cv_d      = cv_value;
          state_d   = REQ;
        end
      end
      REQ: begin
        host_req_valid = 1'b1;
        host_req_wr    = !is_rd;
        host_req_addr  = is_cv ? addr_q
                       : {addr_q[ADDR_W-1:6], 6'b0};
        host_req_beats = is_cv ? 4'd1 : 4'd8;
        if (host_req_ready)
          state_d = is_rd ? RD_BEAT : WR_BEAT;
      end
      RD_BEAT: begin
        if (host_rd_valid) begin
          rd_line_d[HOST_W*beat_q +: HOST_W] = host_rd_data;
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST) begin
            beat_d  = '0;
            state_d = RD_DONE;
          end
        end
      end
      RD_DONE: begin
        tx_done = 1'b1;
        state_d = RD_VLD;
      end
      RD_VLD: begin
        rd_valid = 1'b1;
        state_d  = DRAIN;
      end
      WR_BEAT: begin
        host_wr_valid = 1'b1;
        host_wr_data  = is_cv ? HOST_W'(cv_q)
                      : wr_line_q[HOST_W*beat_q +: HOST_W];
        if (host_wr_ready) begin
          beat_d = beat_q + 3'd1;
          if (is_cv || beat_q == LAST) begin
            beat_d  = '0;
            state_d = WR_DONE;
          end
        end
      end
      WR_DONE: begin
        tx_done = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (op == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog expiry: finish the transfer, zero-filling unreceived words.
    if (to_hit) begin
      state_d = is_rd ? RD_DONE : WR_DONE;
      beat_d  = '0;
      if (is_rd) begin
        for (int i = 0; i < NB; i++)
          if (i >= int'(beat_q))
            rd_line_d[HOST_W*i +: HOST_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      cv_q      <= '0;
      beat_q    <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      cv_q      <= cv_d;
      beat_q    <= beat_d;
      rd_line_q <= rd_line_d;
    end
  end

`ifdef HOST_SHIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          active, hs;

  always_comb begin
    active = state_q inside {REQ, RD_BEAT, WR_BEAT};
    hs = (state_q == REQ     && host_req_ready)
      || (state_q == RD_BEAT && host_rd_valid)
      || (state_q == WR_BEAT && host_wr_ready);
    to_hit = active && !hs
          && tmr_q == TW'(TIMEOUT_CYC - 1);
    tmr_d = (active && !hs) ? tmr_q + 1'b1 : '0;
    err_d = err_q | to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign shim_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign to_hit     = 1'b0;
  assign shim_err   = 1'b0;
`endif

endmodule

// File: tb/tb_host_line_shim.sv
// tb_host_line_shim: directed + randomized checks of host_line_shim
// against a transaction-level model of the line/host protocol.
module tb_host_line_shim;
  localparam int HW = 64;
  localparam int LW = 512;
  localparam int AW = 32;
  typedef logic [LW-1:0] w_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] io_addr = '0;
  logic [LW-1:0] line_wr_data = '0;
  logic [63:0]   cv_value = '0;
  logic [LW-1:0] line_rd_data;
  logic          tx_done, rd_valid;
  logic          host_req_valid;
  logic          host_req_ready = 1'b0;
  logic          host_req_wr;
  logic [AW-1:0] host_req_addr;
  logic [3:0]    host_req_beats;
  logic          host_wr_valid;
  logic          host_wr_ready = 1'b0;
  logic [HW-1:0] host_wr_data;
  logic          host_rd_valid = 1'b0;
  logic [HW-1:0] host_rd_data = '0;
  logic          shim_err;

  int pass_cnt = 0, fail_cnt = 0, tot = 0;
  int tx_cnt = 0, rv_cnt = 0, req_cnt = 0;
  logic [LW-1:0] model_line = '0;

  always #5 clk = ~clk;

  host_line_shim #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .io_addr(io_addr),
    .line_wr_data(line_wr_data), .cv_value(cv_value),
    .line_rd_data(line_rd_data), .tx_done(tx_done),
    .rd_valid(rd_valid), .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready), .host_req_wr(host_req_wr),
    .host_req_addr(host_req_addr), .host_req_beats(host_req_beats),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_data(host_wr_data), .host_rd_valid(host_rd_valid),
    .host_rd_data(host_rd_data), .shim_err(shim_err)
  );

  always @(posedge clk) begin
    if (tx_done) tx_cnt++;
    if (rd_valid) rv_cnt++;
    if (host_req_valid && host_req_ready) req_cnt++;
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    tot++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [1:0] o, input logic [AW-1:0] a,
                     input logic [LW-1:0] wd, input logic [63:0] cv,
                     input bit dir);
    logic [LW-1:0] exp_line;
    logic [HW-1:0] beat, exp_w;
    logic rdy;
    int n, k, nb, t0, v0, r0;
    nb = (o == 2'b10) ? 1 : 8;
    t0 = tx_cnt;
    v0 = rv_cnt;
    @(negedge clk);
    op = o; io_addr = a; line_wr_data = wd; cv_value = cv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_req_valid && n < 10);
    chk("req_valid", w_t'(host_req_valid), w_t'(1'b1));
    chk("req_addr", w_t'(host_req_addr),
        w_t'((o == 2'b10) ? a : {a[AW-1:6], 6'b0}));
    chk("req_beats", w_t'(host_req_beats), w_t'(nb));
    chk("req_wr", w_t'(host_req_wr), w_t'(o != 2'b01));
    repeat ($urandom_range(0, 3)) begin
      host_rd_valid = 1'($urandom);
      host_rd_data = {$urandom, $urandom};
      @(negedge clk);
    end
    host_req_ready = 1'b1;
    @(negedge clk);
    host_req_ready = 1'b0;
    host_rd_valid = 1'b0;
    op = dir ? o : 2'($urandom);
    io_addr = $urandom;
    cv_value = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) line_wr_data[32*i +: 32] = $urandom;
    if (o == 2'b01) begin
      exp_line = '0;
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        beat = dir ? {32'(2*i+1), 32'(2*i)} : {$urandom, $urandom};
        exp_line[HW*i +: HW] = beat;
        host_rd_valid = 1'b1;
        host_rd_data = beat;
        @(negedge clk);
        host_rd_valid = 1'b0;
      end
      chk("rd_tx_done", w_t'(tx_done), w_t'(1'b1));
      chk("rd_vld_early", w_t'(rd_valid), w_t'(1'b0));
      chk("rd_line", line_rd_data, exp_line);
      @(negedge clk);
      chk("rd_valid", w_t'(rd_valid), w_t'(1'b1));
      chk("rd_tx_once", w_t'(tx_done), w_t'(1'b0));
      chk("rd_line_hold", line_rd_data, exp_line);
      model_line = exp_line;
      if (dir) begin
        chk("line_lo", w_t'(line_rd_data[31:0]), w_t'(0));
        chk("line_hi", w_t'(line_rd_data[511:480]), w_t'(15));
      end
    end else begin
      k = 0;
      n = 0;
      while (k < nb && n < 64) begin
        exp_w = (o == 2'b10) ? cv : wd[HW*k +: HW];
        chk("wr_valid", w_t'(host_wr_valid), w_t'(1'b1));
        chk("wr_data", w_t'(host_wr_data), w_t'(exp_w));
        rdy = dir ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
        host_wr_ready = rdy;
        @(negedge clk);
        if (rdy) k++;
        n++;
      end
      host_wr_ready = 1'b0;
      chk("wr_count", w_t'(k), w_t'(nb));
      chk("wr_tx_done", w_t'(tx_done), w_t'(1'b1));
      chk("wr_no_rdvld", w_t'(rd_valid), w_t'(1'b0));
      chk("wr_valid_end", w_t'(host_wr_valid), w_t'(1'b0));
      chk("wr_line_keep", line_rd_data, model_line);
    end
    if (dir) begin
      r0 = req_cnt;
      repeat (20) @(negedge clk);
      chk("held_op_reissue", w_t'(req_cnt - r0), w_t'(0));
    end
    op = 2'b00;
    repeat (3) @(negedge clk);
    chk("tx_pulses", w_t'(tx_cnt - t0), w_t'(1));
    chk("rv_pulses", w_t'(rv_cnt - v0), w_t'(o == 2'b01));
  endtask

  initial begin
    logic [LW-1:0] wd;
    logic [1:0] o;
    int n, t0, v0;
    repeat (2) @(negedge clk);
    chk("rst_outs", w_t'({tx_done, rd_valid, host_req_valid, host_req_wr,
        host_req_addr, host_req_beats, host_wr_valid, host_wr_data,
        shim_err}), w_t'(0));
    chk("rst_line", line_rd_data, w_t'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_quiet", w_t'(host_req_valid), w_t'(0));

    txn(2'b01, 32'h2000_0004, '0, '0, 1'b1);
    for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'(i);
    txn(2'b11, 32'h1000_0000, wd, '0, 1'b1);
    txn(2'b10, 32'h3000_0010, '0, 64'hDEAD_BEEF_0000_0001, 1'b1);
    for (int t = 0; t < 10; t++) begin
      o = 2'($urandom_range(1, 3));
      for (int i = 0; i < 16; i++) wd[32*i +: 32] = $urandom;
      txn(o, $urandom, wd, {$urandom, $urandom}, 1'b0);
    end

    @(negedge clk);
    op = 2'b01;
    io_addr = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_req_valid && n < 10);
    host_req_ready = 1'b1;
    @(negedge clk);
    host_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_rd_valid = 1'b1;
      host_rd_data = {$urandom, $urandom};
      @(negedge clk);
    end
    t0 = tx_cnt;
    v0 = rv_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", w_t'({tx_done, rd_valid, host_req_valid,
        host_wr_valid, host_req_addr, host_wr_data}), w_t'(0));
    chk("arst_line", line_rd_data, w_t'(0));
    host_rd_valid = 1'b0;
    op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_pulses", w_t'((tx_cnt - t0) + (rv_cnt - v0)), w_t'(0));
    chk("post_rst_req", w_t'(host_req_valid), w_t'(0));

    t0 = tx_cnt;
    v0 = rv_cnt;
    @(negedge clk);
    op = 2'b01;
    io_addr = $urandom;
`ifdef HOST_SHIM_TIMEOUT_EN
    repeat (16) @(negedge clk);
    chk("to_early", w_t'({tx_done, shim_err}), w_t'(0));
    @(negedge clk);
    chk("to_tx_done", w_t'(tx_done), w_t'(1'b1));
    chk("to_err", w_t'(shim_err), w_t'(1'b1));
    @(negedge clk);
    chk("to_rd_valid", w_t'(rd_valid), w_t'(1'b1));
    chk("to_zero_line", line_rd_data, w_t'(0));
    op = 2'b00;
    repeat (4) @(negedge clk);
    chk("to_err_sticky", w_t'(shim_err), w_t'(1'b1));
    chk("to_pulses", w_t'({tx_cnt - t0, rv_cnt - v0}), w_t'({32'd1, 32'd1}));
`else
    repeat (100) @(negedge clk);
    chk("noto_pulses", w_t'((tx_cnt - t0) + (rv_cnt - v0)), w_t'(0));
    chk("noto_err", w_t'(shim_err), w_t'(0));
    chk("noto_waiting", w_t'(host_req_valid), w_t'(1'b1));
`endif
    rst_n = 1'b0;
    op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("final_err_clr", w_t'(shim_err), w_t'(0));

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
